// File: rtl/ut_ctrl_if.sv
// Handshake and datapath-control bundle between the ut_ctrl sequencer and its
// datapath/memory. "master" is the controller side, "slave" the datapath side.
interface ut_ctrl_if;
  logic        start;
  logic        halt_req;
  logic [31:0] instr;
  logic        ALU_carry;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] rd_data;
  logic        sel_alu_func;
  logic        ir_en;
  logic        immgen_bus_en;
  logic        ALU_bus_en;
  logic        a_en;
  logic        b_en;
  logic        pc_en;
  logic        pc_bus_en;
  logic        rf_wen;
  logic        rf_ren;
  logic        rf_bus_en;
  logic        rd_bus_en;
  logic [4:0]  rf_addr_sel;
  logic        busy;
  logic        trap;
  logic        carry_flag;
  logic [15:0] retired;

  modport master (
    input  start, halt_req, instr, ALU_carry, mem_ack, mem_rdata,
    output mem_req, rd_data, sel_alu_func, ir_en, immgen_bus_en, ALU_bus_en,
           a_en, b_en, pc_en, pc_bus_en, rf_wen, rf_ren, rf_bus_en, rd_bus_en,
           rf_addr_sel, busy, trap, carry_flag, retired
  );

  modport slave (
    output start, halt_req, instr, ALU_carry, mem_ack, mem_rdata,
    input  mem_req, rd_data, sel_alu_func, ir_en, immgen_bus_en, ALU_bus_en,
           a_en, b_en, pc_en, pc_bus_en, rf_wen, rf_ren, rf_bus_en, rd_bus_en,
           rf_addr_sel, busy, trap, carry_flag, retired
  );
endinterface

// File: rtl/ut_ctrl.sv
// Micro-sequencer for a tiny ADD/SUB/ADDI core: fetch, decode, register
// operand moves, write-back and PC+4 through the shared datapath bus.
module ut_ctrl #(
  parameter int MEM_TO_MAX = 255
) (
  input  logic      clk,
  input  logic      rst,
  ut_ctrl_if.master bus
);

  localparam int CW = $clog2(MEM_TO_MAX + 2);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD_IR, DECODE, RS1, OPB, WB, PC_A, PC_B, PC_W, TRAP
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_ADDI
  } op_t;

  state_t        state, state_nx;
  op_t           op_q, op_dec;
  logic          dec_ok;
  logic [CW-1:0] to_cnt;
  logic [31:0]   rdata_q;
  logic          halt_q;
  logic [4:0]    rs1_q, rs2_q, rd_q;
  logic [15:0]   retired_q;
  logic          carry_q;

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [4:0]    f_rs1, f_rs2, f_rd;

  logic          mem_req, sel_alu_func, ir_en, immgen_bus_en, alu_bus_en;
  logic          a_en, b_en, pc_en, pc_bus_en, rf_wen, rf_ren, rf_bus_en, rd_bus_en;
  logic [31:0]   rd_data;
  logic [4:0]    rf_addr_sel;
  logic          busy;

  assign opcode = bus.instr[6:0];
  assign f_rd   = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign f_rs1  = bus.instr[19:15];
  assign f_rs2  = bus.instr[24:20];
  assign funct7 = bus.instr[31:25];

  // Only x0..x3 exist, so any register index with bits [4:2] set is illegal.
  always_comb begin
    dec_ok = 1'b0;
    op_dec = OP_ADD;
    if (funct3 == 3'b000) begin
      if (opcode == 7'b0110011) begin
        if (f_rs1[4:2] == 3'b000 && f_rs2[4:2] == 3'b000 && f_rd[4:2] == 3'b000) begin
          if (funct7 == 7'b0000000) begin
            dec_ok = 1'b1;
            op_dec = OP_ADD;
          end else if (funct7 == 7'b0100000) begin
            dec_ok = 1'b1;
            op_dec = OP_SUB;
          end
        end
      end else if (opcode == 7'b0010011) begin
        op_dec = OP_ADDI;
        if (f_rs1[4:2] == 3'b000 && f_rd[4:2] == 3'b000) begin
          dec_ok = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt    <= '0;
      rdata_q   <= '0;
      halt_q    <= 1'b0;
      op_q      <= OP_ADD;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      retired_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      to_cnt <= (state == FETCH && !bus.mem_ack) ? to_cnt + 1'b1 : '0;
      if (state == FETCH && bus.mem_ack) begin
        rdata_q <= bus.mem_rdata;
      end
      // Halt is remembered from any busy cycle and honoured at the next PC_W.
      if (state == IDLE) begin
        halt_q <= 1'b0;
      end else if (state != TRAP && bus.halt_req) begin
        halt_q <= 1'b1;
      end
      if (state == DECODE) begin
        op_q  <= op_dec;
        rs1_q <= f_rs1;
        rs2_q <= f_rs2;
        rd_q  <= f_rd;
      end
      if (state == WB) begin
        carry_q <= bus.ALU_carry;
      end
      if (state == PC_W) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    mem_req       = 1'b0;
    sel_alu_func  = 1'b0;
    ir_en         = 1'b0;
    immgen_bus_en = 1'b0;
    alu_bus_en    = 1'b0;
    a_en          = 1'b0;
    b_en          = 1'b0;
    pc_en         = 1'b0;
    pc_bus_en     = 1'b0;
    rf_wen        = 1'b0;
    rf_ren        = 1'b0;
    rf_bus_en     = 1'b0;
    rd_bus_en     = 1'b0;
    rd_data       = 32'd0;
    rf_addr_sel   = 5'd0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nx = FETCH;
      end
      FETCH: begin
        pc_bus_en = 1'b1;
        mem_req   = 1'b1;
        if (bus.mem_ack) begin
          state_nx = LOAD_IR;
        end else if (to_cnt == CW'(MEM_TO_MAX)) begin
          state_nx = TRAP;
        end
      end
      LOAD_IR: begin
        rd_bus_en = 1'b1;
        ir_en     = 1'b1;
        rd_data   = rdata_q;
        state_nx  = DECODE;
      end
      DECODE: begin
        state_nx = dec_ok ? RS1 : TRAP;
      end
      RS1: begin
        rf_addr_sel = rs1_q;
        rf_ren      = 1'b1;
        rf_bus_en   = 1'b1;
        a_en        = 1'b1;
        state_nx    = OPB;
      end
      OPB: begin
        b_en = 1'b1;
        if (op_q == OP_ADDI) begin
          immgen_bus_en = 1'b1;
        end else begin
          rf_addr_sel = rs2_q;
          rf_ren      = 1'b1;
          rf_bus_en   = 1'b1;
        end
        state_nx = WB;
      end
      WB: begin
        alu_bus_en   = 1'b1;
        rf_addr_sel  = rd_q;
        sel_alu_func = (op_q == OP_SUB);
        rf_wen       = (rd_q != 5'd0);
        state_nx     = PC_A;
      end
      PC_A: begin
        pc_bus_en = 1'b1;
        a_en      = 1'b1;
        state_nx  = PC_B;
      end
      PC_B: begin
        rd_bus_en = 1'b1;
        b_en      = 1'b1;
        rd_data   = 32'd4;
        state_nx  = PC_W;
      end
      PC_W: begin
        alu_bus_en = 1'b1;
        pc_en      = 1'b1;
        state_nx   = (halt_q || bus.halt_req) ? IDLE : FETCH;
      end
      TRAP: begin
        busy = 1'b0;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.mem_req       = mem_req;
  assign bus.rd_data       = rd_data;
  assign bus.sel_alu_func  = sel_alu_func;
  assign bus.ir_en         = ir_en;
  assign bus.immgen_bus_en = immgen_bus_en;
  assign bus.ALU_bus_en    = alu_bus_en;
  assign bus.a_en          = a_en;
  assign bus.b_en          = b_en;
  assign bus.pc_en         = pc_en;
  assign bus.pc_bus_en     = pc_bus_en;
  assign bus.rf_wen        = rf_wen;
  assign bus.rf_ren        = rf_ren;
  assign bus.rf_bus_en     = rf_bus_en;
  assign bus.rd_bus_en     = rd_bus_en;
  assign bus.rf_addr_sel   = rf_addr_sel;
  assign bus.busy          = busy;
  assign bus.trap          = (state == TRAP);
  assign bus.carry_flag    = carry_q;
  assign bus.retired       = retired_q;

endmodule
